// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: widths, base opcodes decode interprets from id_op,
// the fetch FIFO entry layout and the default reset PC.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register FIFO with flush; the head entry is readable combinationally
// and reads as zero while the FIFO is empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    assign count = count_reg;
    assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;

    // The fetch credit scheme must never let a push land on a full FIFO.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && !do_pop && (count_reg == (PW+1)'(DEPTH))));

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC and request credit logic, one-cycle synchronous memory
// interface, and a fetch FIFO presenting {pc, instr} to decode.
module instr_fetch
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [6:0]      id_op,
    output logic [24:0]     id_instr,
    output logic [31:0]     id_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] inflight_addr_reg;
    logic            inflight_reg;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic            pop;
    logic            push;
    logic            issue;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign id_valid = (count != '0);
    assign pop      = id_valid && id_ready;

    // Slots already committed: buffered entries surviving this cycle plus the
    // word still on its way back from memory.
    assign credit = {1'b0, count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
    assign issue  = rst_n && !redirect && (credit < (CW+1)'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = pc_reg;

    // A response arriving in a redirect cycle belongs to the old stream and is killed.
    assign push       = inflight_reg && !redirect;
    assign push_entry = '{pc: inflight_addr_reg, instr: imem_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg            <= RESET_PC;
            inflight_reg      <= 1'b0;
            inflight_addr_reg <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) inflight_addr_reg <= pc_reg;
            if (redirect)   pc_reg <= word_align(redirect_pc);
            else if (issue) pc_reg <= pc_reg + 32'd4;
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .count (count),
        .head  (head)
    );

    assign id_op    = head.instr[6:0];
    assign id_instr = head.instr[31:7];
    assign id_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-level reference model checked every cycle,
// plus directed literal checks for reset, backpressure, redirect and wrap.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [6:0]  id_op;
    logic [24:0] id_instr;
    logic [31:0] id_pc;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_op       (id_op),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: word at addr is 0x13 + addr, returned one cycle later.
    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h13 + imem_addr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the decode-visible stream is a queue of fetched PCs.
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_infl_addr;
    bit          m_infl;

    always @(posedge clk) begin
        int  n;
        bit  mpop;
        bit  mreq;
        if (!rst_n) begin
            m_q.delete();
            m_pc   = RST_PC;
            m_infl = 1'b0;
        end else begin
            n    = m_q.size();
            mpop = (n > 0) && id_ready;
            mreq = !redirect && ((n - int'(mpop) + int'(m_infl)) < DEPTH);
            if (mpop) void'(m_q.pop_front());
            if (redirect) begin
                m_q.delete();
                m_infl = 1'b0;
                m_pc   = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (m_infl) m_q.push_back(m_infl_addr);
                m_infl = mreq;
                if (mreq) begin
                    m_infl_addr = m_pc;
                    m_pc        = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        int          n;
        bit          ev;
        bit          er;
        logic [31:0] w;
        n  = m_q.size();
        ev = rst_n && (n > 0);
        er = rst_n && !redirect && ((n - int'(ev && id_ready) + int'(m_infl)) < DEPTH);
        check("m_req", {31'b0, imem_req}, {31'b0, er});
        if (er) check("m_addr", imem_addr, m_pc);
        check("m_valid", {31'b0, id_valid}, {31'b0, ev});
        if (ev) begin
            w = 32'h13 + m_q[0];
            check("m_pc", id_pc, m_q[0]);
            check("m_op", {25'b0, id_op}, {25'b0, w[6:0]});
            check("m_instr", {7'b0, id_instr}, {7'b0, w[31:7]});
        end else begin
            check("m_zero", {id_pc | {25'b0, id_op} | {7'b0, id_instr}}, 32'h0);
        end
    end

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;
        repeat (3) step();

        // Reset release and streaming
        rst_n = 1'b1;
        @(negedge clk);
        check("c0_req", {31'b0, imem_req}, 32'h1);
        check("c0_addr", imem_addr, 32'h100);
        step();
        step();
        id_ready = 1'b0;
        @(negedge clk);
        check("c2_valid", {31'b0, id_valid}, 32'h1);
        check("c2_pc", id_pc, 32'h100);
        check("c2_op", {25'b0, id_op}, 32'h13);
        check("c2_instr", {7'b0, id_instr}, 32'h2);

        // Backpressure for 5 cycles
        repeat (4) step();
        @(negedge clk);
        check("bp_req", {31'b0, imem_req}, 32'h0);
        check("bp_pc", id_pc, 32'h100);
        step();
        id_ready = 1'b1;
        @(negedge clk);
        check("rel_pc0", id_pc, 32'h100);
        check("rel_addr", imem_addr, 32'h108);
        step();
        @(negedge clk);
        check("rel_pc1", id_pc, 32'h104);
        step();
        @(negedge clk);
        check("rel_pc2", id_pc, 32'h108);
        step();
        step();

        // Redirect with a full FIFO
        id_ready = 1'b0;
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h2003;
        step();
        redirect = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        check("rd_valid", {31'b0, id_valid}, 32'h0);
        check("rd_addr", imem_addr, 32'h2000);
        step();
        step();
        @(negedge clk);
        check("rd_pc", id_pc, 32'h2000);

        // Redirect coinciding with a pop
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'h3000;
        step();
        redirect = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rp_pc", id_pc, 32'h3000);

        // PC wrap-around
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("wr_a0", imem_addr, 32'hFFFF_FFF8);
        step();
        @(negedge clk);
        check("wr_a1", imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        check("wr_a2", imem_addr, 32'h0000_0000);
        check("wr_pc", id_pc, 32'hFFFF_FFF8);
        check("wr_op", {25'b0, id_op}, 32'h0B);

        // Back-to-back redirects: the last one wins
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h4000;
        step();
        redirect_pc = 32'h5000;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("bb_addr", imem_addr, 32'h5000);
        check("bb_valid", {31'b0, id_valid}, 32'h0);
        step();
        step();
        @(negedge clk);
        check("bb_pc", id_pc, 32'h5000);

        // Reset mid-stream with a full FIFO
        id_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("rs_valid", {31'b0, id_valid}, 32'h0);
        check("rs_req", {31'b0, imem_req}, 32'h0);
        check("rs_pc", id_pc, 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_addr", imem_addr, 32'h100);
        step();
        step();
        @(negedge clk);
        check("rs_head", id_pc, 32'h100);
        id_ready = 1'b1;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
